clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable, parametrised clock divider generalising the fixed divide-by-10 block. It divides `clk` by any runtime-selected integer N ≥ 2 with exactly 50 % duty for both even and odd N. The divisor changes glitch-free at period boundaries, and a run/stop enable parks the output low. It sits in the clock/timing layer and feeds slow-domain logic such as display scan, step clocks and debounce, alongside a one-cycle `tick` strobe for logic that stays in the `clk` domain.

## Interface
- `WIDTH`, 8: divisor width in bits; legal N is 2 .. 2^WIDTH−1.
- `DEFAULT_DIV`, 10: divisor in force after reset; must be ≥ 2 and < 2^WIDTH.
- `clk`  in  1  system clock (bench period 20 ns).
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; level-sensitive.
- `div_val`  in  WIDTH  requested divisor; sampled only when `div_load` is high.
- `div_load`  in  1  one-cycle load strobe.
- `clk_div`  out  1  divided clock, 50 % duty.
- `tick`  out  1  one-`clk` pulse at the start of each divided period.
- `load_ack`  out  1  one-`clk` pulse when the pending divisor takes effect.
- `load_err`  out  1  one-`clk` pulse, one cycle after a `div_load` with `div_val` < 2.

## Operation
- State:
  - active divisor `N`
  - pending divisor `P` plus valid flag `pv`
  - period counter `cnt` (WIDTH bits)
  - posedge phase flop `r_pos`
  - negedge phase flop `r_neg`
  - FSM {IDLE, RUN}
- Reset (async): N=DEFAULT_DIV, pv=0, cnt=N−1, r_pos=0, r_neg=0, state=IDLE; outputs `clk_div`, `tick`, `load_ack` and `load_err` are all 0.
- Counter: in RUN, cnt advances 0..N−1 and wraps to 0. `r_pos` is registered from the next count: it is 1 for the ceil(N/2) cycles with cnt_next in [0, ceil(N/2)−1].
- `r_neg` samples `r_pos` on the falling edge of `clk`.
- Even N: `clk_div` = `r_pos`.
- Odd N: `clk_div` = `r_pos` & `r_neg`, giving N/2 clk periods high and N/2 low.
- Even/odd select is a registered bit updated together with N, so the output is glitch-free.
- `tick` is 1 in the cycle where cnt = 0.
- Load handling:
  - `div_load` with `div_val` ≥ 2 sets P=`div_val` and pv=1. A second load before application overwrites P; the last one wins and only one `load_ack` is issued.
  - `div_load` with `div_val` < 2 pulses `load_err` and leaves P and pv unchanged.
  - P is applied on the wrap edge (cnt N−1 → 0): N←P, pv←0, `load_ack`=1 in the cycle cnt = 0. The new period begins at that edge.
  - In IDLE, a pending P is applied immediately on the next edge, with `load_ack` pulsed.
- FSM:
  - IDLE → RUN: `en`=1; the first edge sets cnt=0 and `r_pos`=1.
  - RUN → IDLE: `en`=0 is sampled, and the current period completes (cnt reaches N−1). The FSM then parks with cnt=N−1 and `clk_div`=0. No truncated high pulse ever appears.
  - A `en` re-assert while the period is still finishing cancels the stop.
- Simultaneous `div_load` and wrap in the same cycle: the old P (if pv) is applied on this edge; the new value becomes pending for the next wrap.

## Timing
- Even N: `clk_div` rises on the first posedge after the IDLE→RUN edge; period = N·T_clk, high = N/2·T_clk.
- Odd N: `clk_div` rises on the falling edge after `r_pos` rises and falls on a posedge; high = low = N/2·T_clk.
- `tick` is coincident with the cycle in which `clk_div` rises (even N) or half a cycle before it (odd N).
- Divisor change latency: ≤ N_old cycles from `div_load`.
- `rst_n` asserted mid-period: all outputs go to 0 immediately, without waiting for a clock.

## Structure
- Shared package `clk_div_pkg`: `MIN_DIV` = 2, FSM state enum {IDLE, RUN}, a function `half_up(N)` = (N+1)>>1.
- Sub-module `clk_div_neg_stage`: a single negedge flop with async active-low reset, kept separate so its clocking is explicit for timing constraints.

## Test plan
- Reset default: `en`=1 after `rst_n` release -> `clk_div` period 200 ns with 100 ns high; `tick` every 10 cycles; no `load_ack`.
- Odd divide: load 5 while in IDLE, then `en`=1 -> `load_ack` once; `clk_div` period 100 ns with exactly 50 ns high and 50 ns low.
- Boundary change: running at N=10, `div_load` 3 at cnt=4 -> current period completes at 200 ns; next periods are 60 ns with 30 ns high; `load_ack` in the cnt=0 cycle.
- Illegal / overwrite: `div_load` 1 -> `load_err` pulse and N unchanged. Loads of 4 and then 6 within one period -> a single `load_ack`, N=6.
- Stop: `en`=0 mid-high phase at N=8 -> high phase completes, output low from the period end, `tick` stops; re-enable -> rise on the next edge.
- Async reset mid-period at N=7 -> `clk_div`, `tick` and `load_ack` are 0 immediately; N returns to 10.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, FSM encoding and helpers for the programmable clock divider.
package clk_div_pkg;
  localparam int MIN_DIV = 2;
  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;
  function automatic int unsigned half_up(input int unsigned n);
    return (n + 1) >> 1;
  endfunction
endpackage

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control and output bundle of the programmable clock divider.
interface clk_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             clk_div;
  logic             tick;
  logic             load_ack;
  logic             load_err;
  modport master (output en, div_val, div_load, input clk_div, tick, load_ack, load_err);
  modport slave (input en, div_val, div_load, output clk_div, tick, load_ack, load_err);
endinterface

// File: rtl/clk_div_neg_stage.sv
// clk_div_neg_stage: single falling-edge flop, isolated so its clocking is explicit for timing constraints.
module clk_div_neg_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b0;
    else q <= d;
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable 50%-duty clock divider with boundary-aligned divisor change
// and a run/stop enable that always finishes the current period before parking low.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input logic           clk,
  input logic           rst_n,
  clk_div_prog_if.slave bus
);
  localparam logic [0:0]       ST_IDLE = IDLE;
  localparam logic [0:0]       ST_RUN  = RUN;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN     = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] DEF     = WIDTH'(DEFAULT_DIV);
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, p_q, p_d, cnt_q, cnt_d;
  logic             pv_q, pv_d, odd_q, odd_d, r_pos_q, r_pos_d;
  logic             ack_q, ack_d, err_q, err_d;
  logic             r_neg, wrap, apply, load_ok;
  always_comb begin
    wrap    = state_q == ST_RUN && cnt_q == n_q - ONE;
    apply   = pv_q && (state_q == ST_IDLE || wrap);
    load_ok = bus.div_load && bus.div_val >= MIN;
    n_d     = apply ? p_q : n_q;
    odd_d   = n_d[0];
    p_d     = load_ok ? bus.div_val : p_q;
    pv_d    = load_ok || (pv_q && !apply);
    state_d = (state_q == ST_RUN && !wrap) || bus.en ? ST_RUN : ST_IDLE;
    // parking at N-1 keeps r_pos low and makes the restart edge land on count 0
    cnt_d   = state_d == ST_IDLE ? n_d - ONE : (state_q == ST_RUN && !wrap) ? cnt_q + ONE : '0;
    r_pos_d = cnt_d < WIDTH'(half_up(32'(n_d)));
    ack_d   = apply;
    err_d   = bus.div_load && bus.div_val < MIN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= DEF;
      p_q     <= DEF;
      pv_q    <= 1'b0;
      cnt_q   <= DEF - ONE;
      odd_q   <= DEF[0];
      r_pos_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
      cnt_q   <= cnt_d;
      odd_q   <= odd_d;
      r_pos_q <= r_pos_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  clk_div_neg_stage u_neg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (r_pos_q),
    .q     (r_neg)
  );
  // odd N: the half-cycle-late copy trims the rising edge so high and low are N/2 each
  assign bus.clk_div  = odd_q ? r_pos_q & r_neg : r_pos_q;
  assign bus.tick     = cnt_q == '0;
  assign bus.load_ack = ack_q;
  assign bus.load_err = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed table, hand-written corner sequences and random stimulus against a phase model.
module tb_clk_div_prog;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;
  clk_div_prog_if #(.WIDTH(8)) bus ();
  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  int vectors = 0, miscompares = 0;
  int acks = 0, errs = 0, ticks = 0;
  logic l_hi0, l_tick, l_ack, l_err;
  time last_rise = 0, prev_rise = 0, last_fall = 0;
  always @(posedge bus.clk_div) begin prev_rise = last_rise; last_rise = $time; end
  always @(negedge bus.clk_div) last_fall = $time;
  // model: divisor, position within the period, run flag, and at most one pending divisor
  int m_n = 10, m_k = 9;
  bit m_run = 0, m_ack = 0, m_err = 0;
  int m_pend[$];
  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chkn(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_edge(input bit e, input bit ld, input int v);
    bit wrap = m_run && m_k == m_n - 1;
    m_ack = 0;
    m_err = ld && v < 2;
    if ((!m_run || wrap) && m_pend.size() > 0) begin m_n = m_pend.pop_front(); m_ack = 1; end
    if (m_run && !wrap) m_k++;
    else if (e) begin m_run = 1; m_k = 0; end
    else begin m_run = 0; m_k = m_n - 1; end
    if (ld && v >= 2) begin m_pend.delete(); m_pend.push_back(v); end
  endtask
  // high for N consecutive half-cycles, starting half a cycle late when N is odd
  function automatic bit exp_div(input int h);
    int j = 2 * m_k + h;
    int s = m_n % 2;
    return m_run && j >= s && j < s + m_n;
  endfunction
  task automatic step(input bit e, input bit ld, input logic [7:0] v);
    bus.en = e; bus.div_load = ld; bus.div_val = v;
    @(posedge clk);
    model_edge(e, ld, int'(v));
    #5;
    l_hi0 = bus.clk_div; l_tick = bus.tick; l_ack = bus.load_ack; l_err = bus.load_err;
    chk1("clk_div_h0", l_hi0, exp_div(0));
    chk1("tick", l_tick, m_run && m_k == 0);
    chk1("load_ack", l_ack, m_ack);
    chk1("load_err", l_err, m_err);
    acks += int'(l_ack); errs += int'(l_err); ticks += int'(l_tick);
    @(negedge clk);
    #5;
    chk1("clk_div_h1", bus.clk_div, exp_div(1));
  endtask
  task automatic do_reset();
    rst_n = 1'b0; bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
    m_n = 10; m_k = 9; m_run = 0; m_pend.delete();
    #1;
    chk1("rst_clk_div", bus.clk_div, 1'b0);
    chk1("rst_tick", bus.tick, 1'b0);
    chk1("rst_load_ack", bus.load_ack, 1'b0);
    chk1("rst_load_err", bus.load_err, 1'b0);
    #1 rst_n = 1'b1;
  endtask
  task automatic measure(input string tag, input int warm, input int per, input int hi);
    repeat (warm) step(1, 0, 0);
    for (int i = 0; i < 300 && bus.clk_div; i++) step(1, 0, 0);
    chkn({tag, "_period"}, int'(last_rise - prev_rise), per);
    chkn({tag, "_high"}, int'(last_fall - last_rise), hi);
  endtask
  typedef struct {
    bit         ld;
    logic [7:0] val;
    int         per;
    int         hi;
    int         n_ack;
    int         n_err;
  } vec_t;
  vec_t tbl [9];
  initial begin
    bit en_r;
    int lat;
    bit found;
    tbl[0] = '{0, 8'd0,   200,  100,  0, 0};
    tbl[1] = '{1, 8'd5,   100,  50,   1, 0};
    tbl[2] = '{1, 8'd3,   60,   30,   1, 0};
    tbl[3] = '{1, 8'd2,   40,   20,   1, 0};
    tbl[4] = '{1, 8'd1,   200,  100,  0, 1};
    tbl[5] = '{1, 8'd0,   200,  100,  0, 1};
    tbl[6] = '{1, 8'd255, 5100, 2550, 1, 0};
    tbl[7] = '{1, 8'd8,   160,  80,   1, 0};
    tbl[8] = '{1, 8'd7,   140,  70,   1, 0};
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
    #1 do_reset();
    @(negedge clk);
    #5;
    for (int t = 0; t < 9; t++) begin
      do_reset();
      acks = 0; errs = 0;
      step(0, tbl[t].ld, tbl[t].val);
      step(0, 0, 0);
      measure($sformatf("tbl%0d", t), 2 * tbl[t].per / 20 + 4, tbl[t].per, tbl[t].hi);
      chkn($sformatf("tbl%0d_acks", t), acks, tbl[t].n_ack);
      chkn($sformatf("tbl%0d_errs", t), errs, tbl[t].n_err);
    end
    // divisor change requested mid-period takes effect at the wrap
    do_reset();
    repeat (5) step(1, 0, 0);
    step(1, 1, 8'd3);
    lat = 0; found = 0;
    for (int i = 0; i < 12 && !found; i++) begin step(1, 0, 0); lat++; found = l_ack; end
    chkn("bnd_ack_latency", lat, 5);
    chk1("bnd_ack_with_tick", l_tick, 1'b1);
    measure("bnd", 7, 60, 30);
    // illegal load, then two loads in one period: last one wins, single ack
    do_reset();
    step(1, 0, 0);
    step(1, 1, 8'd1);
    chk1("ill_err_pulse", l_err, 1'b1);
    step(1, 0, 0);
    chk1("ill_err_cleared", l_err, 1'b0);
    step(1, 1, 8'd4);
    step(1, 0, 0);
    step(1, 1, 8'd6);
    acks = 0;
    repeat (12) step(1, 0, 0);
    chkn("ovw_single_ack", acks, 1);
    measure("ovw", 6, 120, 60);
    // stop mid-high at N=8, then restart
    do_reset();
    step(0, 1, 8'd8);
    step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    ticks = 0;
    step(0, 0, 0);
    chk1("stop_high_completes", l_hi0, 1'b1);
    repeat (20) step(0, 0, 0);
    chkn("stop_no_ticks", ticks, 0);
    chk1("stop_parked_low", bus.clk_div, 1'b0);
    step(1, 0, 0);
    chk1("restart_rise", l_hi0, 1'b1);
    chk1("restart_tick", l_tick, 1'b1);
    // asynchronous reset in the high phase at N=7
    do_reset();
    step(0, 1, 8'd7);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk1("pre_rst_high", bus.clk_div, 1'b1);
    do_reset();
    measure("post_rst", 25, 200, 100);
    // random stimulus against the model
    en_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else begin
        if ($urandom_range(0, 49) == 0) en_r = !en_r;
        step(en_r, $urandom_range(0, 14) == 0,
             $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12)));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
